// File: rtl/ex_mul_unit_pkg.sv
// Shared definitions for the execute-stage iterative multiplier.
// Holds the controller state encoding, the legal BITS_PER_CYCLE set and flag bit positions.
// Contents: mul_state_t, BPC_LEGAL_MASK, bpc_legal(), FLAG_N/FLAG_Z, nz_flags().
package ex_mul_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  // Bit b set means b multiplier bits per iteration is supported (1, 2 or 4).
  localparam logic [4:0] BPC_LEGAL_MASK = 5'b10110;

  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  function automatic bit bpc_legal(input int bpc);
    logic [2:0] idx;
    idx = bpc[2:0];
    return (bpc >= 1) && (bpc <= 4) && BPC_LEGAL_MASK[idx];
  endfunction

  function automatic logic [1:0] nz_flags(input logic [31:0] value);
    logic [1:0] f;
    f         = '0;
    f[FLAG_N] = value[31];
    f[FLAG_Z] = (value == 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/ex_mul_unit_mul_step.sv
// One radix-2^BITS_PER_CYCLE iteration: acc + mcand * low digit of mplier, operands shifted.
// Latency: purely combinational. Backpressure: none, the caller decides when to register.
// Ports: acc/mcand/mplier in (32b each); acc_next/mcand_next/mplier_next out (32b each).
module mul_step #(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [31:0] acc,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  output logic [31:0] acc_next,
  output logic [31:0] mcand_next,
  output logic [31:0] mplier_next
);

  logic [31:0] digit;

  assign digit       = {{(32 - BITS_PER_CYCLE){1'b0}}, mplier[BITS_PER_CYCLE-1:0]};
  // mcand has already been shifted into place, so the partial product lands at the
  // right weight; anything above bit 31 is dropped, which is the intended low-word result.
  assign acc_next    = acc + (mcand * digit);
  assign mcand_next  = mcand << BITS_PER_CYCLE;
  assign mplier_next = mplier >> BITS_PER_CYCLE;

endmodule

// File: rtl/ex_mul_unit.sv
// Execute-stage MUL/MLA unit: low 32 bits of RD1E*RD2E (+AccValE), BITS_PER_CYCLE bits per cycle.
// Latency: MulDoneE NUM_ITER+1 cycles after StartE is taken in IDLE; one-cycle strobe.
// Backpressure: cannot be stalled itself; StallMulE freezes F/D/E while the multiply runs.
// Ports: clk, reset (sync, active-high); StartE, AbortE, RD1E, RD2E, AccValE, AccEnE, WA3E in;
//        StallMulE, MulDoneE, MulResultE, MulWA3E, MulFlagsE ({N,Z}) out.
module ex_mul_unit
  import ex_mul_unit_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        AbortE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] AccValE,
  input  logic        AccEnE,
  input  logic [3:0]  WA3E,
  output logic        StallMulE,
  output logic        MulDoneE,
  output logic [31:0] MulResultE,
  output logic [3:0]  MulWA3E,
  output logic [1:0]  MulFlagsE
);

  localparam int NUM_ITER = 32 / BITS_PER_CYCLE;
  localparam int CNT_W    = $clog2(NUM_ITER);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_ITER - 1);

  if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
    $error("ex_mul_unit: BITS_PER_CYCLE must be 1, 2 or 4");
  end

  mul_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic [31:0]      mcand, mplier, acc;
  logic [31:0]      acc_next, mcand_next, mplier_next;
  logic             take_start;

  assign take_start = StartE && !AbortE;

  mul_step #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_next   (acc_next),
    .mcand_next (mcand_next),
    .mplier_next(mplier_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    StallMulE  = 1'b0;
    MulDoneE   = 1'b0;
    case (state)
      IDLE: begin
        // Raised in the start cycle itself so the hazard unit freezes E immediately.
        StallMulE = StartE;
        if (take_start) state_next = BUSY;
      end
      BUSY: begin
        StallMulE = 1'b1;
        if (AbortE)                  state_next = IDLE;
        else if (count == LAST_ITER) state_next = DONE;
      end
      DONE: begin
        // StartE here is still the instruction just finished, so it never restarts.
        MulDoneE   = !AbortE;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      MulResultE <= '0;
      MulWA3E    <= '0;
      MulFlagsE  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_start) begin
            mcand   <= RD1E;
            mplier  <= RD2E;
            MulWA3E <= WA3E;
            acc     <= AccEnE ? AccValE : 32'd0;
            count   <= '0;
          end
        end
        BUSY: begin
          if (!AbortE) begin
            acc    <= acc_next;
            mcand  <= mcand_next;
            mplier <= mplier_next;
            count  <= count + 1'b1;
            // Register the final sum on the way into DONE so it is stable for the strobe.
            if (count == LAST_ITER) begin
              MulResultE <= acc_next;
              MulFlagsE  <= nz_flags(acc_next);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Self-checking bench for ex_mul_unit at BITS_PER_CYCLE = 2, 1 and 4 side by side.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Each instance has its own StartE; data, AbortE and reset are shared.
module tb_ex_mul_unit;

  logic             clk = 1'b0;
  logic             reset;
  logic             abort;
  logic [2:0]       start;
  logic [31:0]      rd1, rd2, accv;
  logic             acc_en;
  logic [3:0]       wa3;
  logic [2:0]       stall, done;
  logic [2:0][31:0] res;
  logic [2:0][3:0]  wa_o;
  logic [2:0][1:0]  flags_o;

  int checks = 0;
  int errors = 0;
  int done_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  ex_mul_unit #(.BITS_PER_CYCLE(2)) u_bpc2 (
    .clk(clk), .reset(reset), .StartE(start[0]), .AbortE(abort), .RD1E(rd1), .RD2E(rd2),
    .AccValE(accv), .AccEnE(acc_en), .WA3E(wa3), .StallMulE(stall[0]), .MulDoneE(done[0]),
    .MulResultE(res[0]), .MulWA3E(wa_o[0]), .MulFlagsE(flags_o[0]));

  ex_mul_unit #(.BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .reset(reset), .StartE(start[1]), .AbortE(abort), .RD1E(rd1), .RD2E(rd2),
    .AccValE(accv), .AccEnE(acc_en), .WA3E(wa3), .StallMulE(stall[1]), .MulDoneE(done[1]),
    .MulResultE(res[1]), .MulWA3E(wa_o[1]), .MulFlagsE(flags_o[1]));

  ex_mul_unit #(.BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .reset(reset), .StartE(start[2]), .AbortE(abort), .RD1E(rd1), .RD2E(rd2),
    .AccValE(accv), .AccEnE(acc_en), .WA3E(wa3), .StallMulE(stall[2]), .MulDoneE(done[2]),
    .MulResultE(res[2]), .MulWA3E(wa_o[2]), .MulFlagsE(flags_o[2]));

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) if (done[i]) done_cnt[i]++;
  end

  function automatic int num_iter(input int idx);
    return (idx == 0) ? 16 : (idx == 1) ? 32 : 8;
  endfunction

  // Reference: plain 64-bit arithmetic, keep the low word.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic en);
    logic [63:0] p;
    p = 64'(a) * 64'(b) + (en ? 64'(c) : 64'd0);
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic en, input logic [3:0] wa);
    next_cycle();
    rd1 = a; rd2 = b; accv = c; acc_en = en; wa3 = wa;
    start[idx] = 1'b1;
  endtask

  // Called in the start cycle T; returns at the falling edge of the DONE cycle.
  task automatic wait_done(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic en, input logic [3:0] wa);
    int cyc = 0;
    int stalls = 0;
    logic seen = 1'b0;
    logic [31:0] exp_r;
    exp_r = ref_mul(a, b, c, en);
    while (cyc <= 100) begin
      @(negedge clk);
      if (done[idx]) begin
        seen = 1'b1;
        break;
      end
      if (stall[idx]) stalls++;
      next_cycle();
      cyc++;
    end
    check($sformatf("done_seen[%0d]", idx), 32'(seen), 32'd1);
    check($sformatf("done_cycle[%0d]", idx), cyc, num_iter(idx) + 1);
    check($sformatf("stall_len[%0d]", idx), stalls, num_iter(idx) + 1);
    check($sformatf("stall_in_done[%0d]", idx), 32'(stall[idx]), 32'd0);
    check($sformatf("result[%0d]", idx), res[idx], exp_r);
    check($sformatf("wa3[%0d]", idx), 32'(wa_o[idx]), 32'(wa));
    check($sformatf("flags[%0d]", idx), 32'(flags_o[idx]), 32'({exp_r[31], exp_r == 32'd0}));
  endtask

  task automatic finish_op(input int idx);
    next_cycle();
    start[idx] = 1'b0;
    @(negedge clk);
    check($sformatf("done_one_cycle[%0d]", idx), 32'(done[idx]), 32'd0);
    check($sformatf("stall_after[%0d]", idx), 32'(stall[idx]), 32'd0);
  endtask

  task automatic run_mul(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic en, input logic [3:0] wa);
    start_op(idx, a, b, c, en, wa);
    wait_done(idx, a, b, c, en, wa);
    finish_op(idx);
  endtask

  initial begin
    int snap;
    reset = 1'b1; abort = 1'b0; start = '0;
    rd1 = '0; rd2 = '0; accv = '0; acc_en = 1'b0; wa3 = '0;
    repeat (3) next_cycle();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_stall[%0d]", i), 32'(stall[i]), 32'd0);
      check($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
      check($sformatf("rst_result[%0d]", i), res[i], 32'd0);
      check($sformatf("rst_wa3[%0d]", i), 32'(wa_o[i]), 32'd0);
      check($sformatf("rst_flags[%0d]", i), 32'(flags_o[i]), 32'd0);
    end
    next_cycle();
    reset = 1'b0;

    // Directed products on every width.
    for (int i = 0; i < 3; i++) begin
      run_mul(i, 32'd3, 32'd5, 32'd0, 1'b0, 4'd4);
      run_mul(i, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd1);
      run_mul(i, 32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd2);
      run_mul(i, 32'd7, 32'd6, 32'd100, 1'b1, 4'd3);
      run_mul(i, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'd5);
    end

    // Abort in BUSY at T+5: back to IDLE at T+6 with no strobe.
    next_cycle();
    snap = done_cnt[0];
    start_op(0, 32'd123, 32'd456, 32'd0, 1'b0, 4'd6);
    repeat (5) next_cycle();
    @(negedge clk);
    check("abort_busy_stall", 32'(stall[0]), 32'd1);
    abort = 1'b1;
    start[0] = 1'b0;
    next_cycle();
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle_stall", 32'(stall[0]), 32'd0);
    check("abort_no_done", 32'(done[0]), 32'd0);
    repeat (20) next_cycle();
    check("abort_done_count", done_cnt[0] - snap, 0);
    run_mul(0, 32'd2, 32'd2, 32'd0, 1'b0, 4'd7);

    // Back-to-back with StartE held through DONE.
    next_cycle();
    snap = done_cnt[0];
    start_op(0, 32'd9, 32'd9, 32'd0, 1'b0, 4'd8);
    wait_done(0, 32'd9, 32'd9, 32'd0, 1'b0, 4'd8);
    start_op(0, 32'd10, 32'd10, 32'd0, 1'b0, 4'd9);
    wait_done(0, 32'd10, 32'd10, 32'd0, 1'b0, 4'd9);
    finish_op(0);
    repeat (20) next_cycle();
    check("b2b_done_count", done_cnt[0] - snap, 2);

    // Reset at T+8 mid-multiply.
    snap = done_cnt[0];
    start_op(0, 32'd77, 32'd77, 32'd0, 1'b0, 4'd12);
    repeat (8) next_cycle();
    reset = 1'b1;
    start[0] = 1'b0;
    next_cycle();
    @(negedge clk);
    check("midrst_stall", 32'(stall[0]), 32'd0);
    check("midrst_done", 32'(done[0]), 32'd0);
    check("midrst_result", res[0], 32'd0);
    check("midrst_wa3", 32'(wa_o[0]), 32'd0);
    check("midrst_flags", 32'(flags_o[0]), 32'd0);
    next_cycle();
    reset = 1'b0;
    check("midrst_done_count", done_cnt[0] - snap, 0);
    run_mul(0, 32'd1, 32'd1, 32'd0, 1'b0, 4'd11);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 6; k++) begin
        logic [31:0] a, b, c;
        logic        en;
        logic [3:0]  wa;
        a  = $urandom;
        b  = (k == 0) ? 32'($urandom_range(0, 255)) : $urandom;
        c  = $urandom;
        en = 1'($urandom_range(0, 1));
        wa = 4'($urandom_range(0, 15));
        run_mul(i, a, b, c, en, wa);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
